pipeline_debug_sequencer: RTL and testbench
===========================================

# pipeline_debug_sequencer

Debug controller that owns the pipeline-wide halt/freeze line and the register-file debug read port of the MIPS pipeline. It accepts single-byte commands from the UART receiver to run, step, halt and dump the register bank. It serializes register contents as bytes to the UART transmitter over a valid/ready stream. It sits between the UART pair and the pipeline stages: instruction fetch, decode, execute, memory and writeback.

## Interface
- `NB_DATA`, 32, register width in bits
- `NB_REG_ADDR`, 5, register-address width
- `N_REGS`, 32, registers dumped per `r` command
- `i_clk`  in  1  pipeline clock
- `i_reset`  in  1  reset; asynchronous, active-high
- `i_cmd_valid`  in  1  command byte present
- `i_cmd_data`  in  8  command byte
- `o_cmd_ready`  out  1  sequencer can take a command
- `o_tx_valid`  out  1  output byte present
- `o_tx_data`  out  8  output byte
- `i_tx_ready`  in  1  transmitter accepts byte
- `o_halt`  out  1  freezes all pipeline stages when 1
- `i_prog_halt`  in  1  HALT instruction (0xFFFFFFFF) detected in decode
- `o_r_addr`  out  `NB_REG_ADDR`  register debug read address
- `i_r_data`  in  `NB_DATA`  register debug read data; combinational, valid in the same cycle
- `o_prog_done`  out  1  sticky flag: program reached HALT
- `o_state`  out  3  current FSM state, for the LEDs

## Operation
- Commands: 0x63 `c` run, 0x73 `s` step, 0x68 `h` halt, 0x72 `r` dump. Any other byte is consumed and ignored.
- **IDLE**
  - `o_halt`=1, `o_cmd_ready`=1.
  - `c` → RUN.
  - `s` → STEP.
  - `r` → DUMP_LOAD with address 0.
  - `h` → no effect.
  - If `o_prog_done`=1, `c` and `s` are ignored.
- **RUN**
  - `o_halt`=0, `o_cmd_ready`=1.
  - `h` → IDLE. Other commands are ignored.
  - `i_prog_halt`=1 → set `o_prog_done` and go to DUMP_LOAD (auto-dump).
  - If `h` and `i_prog_halt` occur in the same cycle, `i_prog_halt` wins.
- **STEP**
  - `o_halt`=0 for exactly one cycle, `o_cmd_ready`=0, then IDLE.
  - `i_prog_halt` in this cycle → set `o_prog_done` and go to DUMP_LOAD.
- **DUMP_LOAD**
  - `o_halt`=1, `o_cmd_ready`=0.
  - Latch `i_r_data` at `o_r_addr` into the 32-bit shift register and clear the byte count → DUMP_SEND.
- **DUMP_SEND**
  - Present byte [31:24] of the shift register (big-endian).
  - On `o_tx_valid & i_tx_ready`: shift left by 8 and increment the byte count.
  - After the 4th byte:
    - address == `N_REGS`-1 → CYCLES (macro on) or IDLE (macro off);
    - otherwise address+1 → DUMP_LOAD.
- **CYCLES** (macro on only): send the 4 cycle-counter bytes, MSB first, then go to IDLE.
- `o_r_addr` holds 0 outside the dump states.

## Timing
- Reset values: state IDLE, `o_halt`=1, `o_cmd_ready`=1, `o_tx_valid`=0, `o_tx_data`=0x00, `o_r_addr`=0, `o_prog_done`=0, cycle counter 0.
- Reset asserted mid-dump aborts the dump immediately. No partial byte is retried.
- A command is accepted on the edge where `i_cmd_valid & o_cmd_ready`. The new state and its outputs take effect on the next cycle.
- `o_halt` is registered and decoded from the state. After `c` is accepted at edge N, the pipeline advances from cycle N+1.
- Dump latency: `r` accepted at edge N → DUMP_LOAD in cycle N+1 → first `o_tx_valid` in cycle N+2.
- Minimum dump length is 5 cycles per register (160 cycles) when `i_tx_ready` is held at 1.
- `o_tx_valid`/`o_tx_data` stay stable until the handshake completes. `o_tx_valid` never drops without a handshake.
- `i_r_data` is sampled only in DUMP_LOAD. Writeback is frozen then, so the sampled data is coherent.

## Configuration
- `DBG_CYCLE_COUNT_EN` defined:
  - a 32-bit counter increments on every cycle with `o_halt`=0 and wraps at 2^32;
  - it is cleared only by reset;
  - it is appended as 4 bytes after each dump (132 bytes total).
- Not defined: no counter and no CYCLES state; a dump is 128 bytes.

## Structure
- Package `debug_pkg`:
  - command byte constants;
  - state encoding (3-bit enum: IDLE, RUN, STEP, DUMP_LOAD, DUMP_SEND, CYCLES);
  - `NB_DATA`/`NB_REG_ADDR` defaults.
- One sub-module, `word_serializer`: loads a 32-bit word and emits 4 bytes MSB-first over valid/ready, with a `done` pulse. It is used for both register words and the cycle counter.

## Test plan
- Reset, then send `r` with `i_tx_ready`=1 and the register file preloaded with reg[k]=k*0x01010101 → 128 bytes, 00 00 00 00, 01 01 01 01, …, 1F 1F 1F 1F; `o_halt` stays 1 throughout.
- Send `s` three times from IDLE → `o_halt` low for exactly 3 isolated cycles; PC advances by 12.
- Send `c`, then `h` 20 cycles later → `o_halt`=0 for exactly 20 cycles; with the macro on, the next dump ends with bytes 00 00 00 14.
- Run a program ending in 0xFFFFFFFF → auto-dump starts 2 cycles after `i_prog_halt`; `o_prog_done`=1; a following `c` is ignored.
- Toggle `i_tx_ready` randomly during a dump → byte sequence identical to the first scenario; `o_tx_data` never changes while valid and not ready.
- Assert `i_reset` at byte 50 of a dump → all outputs are at their reset values in the same cycle; a following `r` restarts from reg 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants, command bytes and state encoding for the pipeline debug sequencer.
package debug_pkg;

  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned NB_REG_ADDR = 5;
  localparam int unsigned N_REGS      = 32;
  localparam int unsigned NB_BYTE     = 8;
  localparam int unsigned NB_STATE    = 3;
  localparam int unsigned NB_CYCLE    = 32;

  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h63;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h73;
  localparam logic [NB_BYTE-1:0] CMD_HALT = 8'h68;
  localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h72;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_DUMP_LOAD = 3'd3,
    ST_DUMP_SEND = 3'd4,
    ST_CYCLES    = 3'd5
  } state_e;

endpackage

// File: rtl/pipeline_debug_sequencer_if.sv
// UART-side byte streams: command bytes in, dump bytes out, both valid/ready.
interface pipeline_debug_sequencer_if;
  import debug_pkg::*;

  logic               cmd_valid;
  logic [NB_BYTE-1:0] cmd_data;
  logic               cmd_ready;
  logic               tx_valid;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_ready;

  // master is the UART pair, slave is the sequencer
  modport master (output cmd_valid, cmd_data, tx_ready,
                  input  cmd_ready, tx_valid, tx_data);
  modport slave  (input  cmd_valid, cmd_data, tx_ready,
                  output cmd_ready, tx_valid, tx_data);
endinterface

// File: rtl/pipeline_debug_sequencer_word_serializer.sv
// Loads a 32-bit word and emits it as 4 bytes MSB-first over valid/ready.
module word_serializer
  import debug_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_data,
  input  logic               i_ready,
  output logic               o_done_c
);
  localparam int unsigned NB_COUNT = 2;

  logic [NB_DATA-1:0]  shreg;
  logic [NB_COUNT-1:0] count;
  logic                fire;

  assign fire     = o_valid & i_ready;
  assign o_done_c = fire & (count == NB_COUNT'(3));
  assign o_data   = shreg[NB_DATA-1 -: NB_BYTE];

  // a load always wins so a new word can follow the last byte back-to-back
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg   <= '0;
      count   <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      shreg   <= i_word;
      count   <= '0;
      o_valid <= 1'b1;
    end else if (fire) begin
      shreg <= shreg << NB_BYTE;
      count <= count + NB_COUNT'(1);
      if (count == NB_COUNT'(3)) o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipeline_debug_sequencer.sv
// Debug controller: pipeline halt/step control and register-bank dump over UART.
// Optional DBG_CYCLE_COUNT_EN appends a 32-bit running-cycle counter to each dump.
module pipeline_debug_sequencer
  import debug_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  pipeline_debug_sequencer_if.slave  bus,
  output logic                       o_halt,
  input  logic                       i_prog_halt,
  output logic [NB_REG_ADDR-1:0]     o_r_addr,
  input  logic [NB_DATA-1:0]         i_r_data,
  output logic                       o_prog_done,
  output logic [NB_STATE-1:0]        o_state
);
  state_e                 state, state_nxt;
  logic                   cmd_fire_c;
  logic                   last_reg_c;
  logic                   prog_done_set_c;
  logic                   halt_nxt_c;
  logic                   cmd_ready_nxt_c;
  logic [NB_REG_ADDR-1:0] r_addr_nxt_c;
  logic                   ser_load_c;
  logic [NB_DATA-1:0]     ser_word_c;
  logic                   ser_done_c;

  assign cmd_fire_c = bus.cmd_valid & bus.cmd_ready;
  assign last_reg_c = (o_r_addr == NB_REG_ADDR'(N_REGS - 1));
  assign o_state    = state;

`ifdef DBG_CYCLE_COUNT_EN
  logic [NB_CYCLE-1:0] cycle_cnt;

  // counts every cycle the pipeline is allowed to advance
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      cycle_cnt <= '0;
    else if (!o_halt) cycle_cnt <= cycle_cnt + NB_CYCLE'(1);
  end

  assign ser_load_c = (state == ST_DUMP_LOAD) |
                      ((state == ST_DUMP_SEND) & ser_done_c & last_reg_c);
  assign ser_word_c = (state == ST_DUMP_LOAD) ? i_r_data : NB_DATA'(cycle_cnt);
`else
  assign ser_load_c = (state == ST_DUMP_LOAD);
  assign ser_word_c = i_r_data;
`endif

  word_serializer u_word_serializer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (ser_load_c),
    .i_word   (ser_word_c),
    .o_valid  (bus.tx_valid),
    .o_data   (bus.tx_data),
    .i_ready  (bus.tx_ready),
    .o_done_c (ser_done_c)
  );

  // next state, plus next values of the registered outputs
  always_comb begin
    state_nxt       = state;
    prog_done_set_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          case (bus.cmd_data)
            CMD_RUN:  if (!o_prog_done) state_nxt = ST_RUN;
            CMD_STEP: if (!o_prog_done) state_nxt = ST_STEP;
            CMD_DUMP: state_nxt = ST_DUMP_LOAD;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_prog_halt) begin
          prog_done_set_c = 1'b1;
          state_nxt       = ST_DUMP_LOAD;
        end else if (cmd_fire_c && (bus.cmd_data == CMD_HALT)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_prog_halt) begin
          prog_done_set_c = 1'b1;
          state_nxt       = ST_DUMP_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DUMP_LOAD: state_nxt = ST_DUMP_SEND;
      ST_DUMP_SEND: begin
        if (ser_done_c) begin
          if (!last_reg_c) state_nxt = ST_DUMP_LOAD;
          else
`ifdef DBG_CYCLE_COUNT_EN
            state_nxt = ST_CYCLES;
`else
            state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef DBG_CYCLE_COUNT_EN
      ST_CYCLES: if (ser_done_c) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase

    halt_nxt_c      = !((state_nxt == ST_RUN) || (state_nxt == ST_STEP));
    cmd_ready_nxt_c = (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);

    case (state_nxt)
      ST_DUMP_LOAD: r_addr_nxt_c = (state == ST_DUMP_SEND) ? o_r_addr + NB_REG_ADDR'(1) : '0;
      ST_DUMP_SEND: r_addr_nxt_c = o_r_addr;
      default:      r_addr_nxt_c = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_halt        <= 1'b1;
      bus.cmd_ready <= 1'b1;
      o_r_addr      <= '0;
      o_prog_done   <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_halt        <= halt_nxt_c;
      bus.cmd_ready <= cmd_ready_nxt_c;
      o_r_addr      <= r_addr_nxt_c;
      if (prog_done_set_c) o_prog_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Scoreboard bench for pipeline_debug_sequencer: command-level model, byte queue, halt monitor.
module tb_pipeline_debug_sequencer;
  import debug_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_debug_sequencer_if bus();
  logic                   halt;
  logic                   prog_halt;
  logic                   prog_done;
  logic [NB_REG_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0]     r_data;
  logic [NB_STATE-1:0]    state;
  logic [NB_DATA-1:0]     regs [N_REGS];

  assign r_data = regs[r_addr];

  pipeline_debug_sequencer dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_halt      (halt),
    .i_prog_halt (prog_halt),
    .o_r_addr    (r_addr),
    .i_r_data    (r_data),
    .o_prog_done (prog_done),
    .o_state     (state)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  int          byte_cnt   = 0;
  int          low_cycles = 0;
  int          low_pulses = 0;
  int          pc         = 0;
  logic [31:0] model_cycles;
  bit          rand_ready = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // expected dump: every register big-endian, then the run-cycle count when enabled
  task automatic push_dump();
    for (int k = 0; k < int'(N_REGS); k++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(regs[k][8*b +: 8]);
`ifdef DBG_CYCLE_COUNT_EN
    for (int b = 3; b >= 0; b--) exp_q.push_back(model_cycles[8*b +: 8]);
`endif
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: got no ready required ready for %h", c);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (state == 3'(ST_IDLE) && exp_q.size() == 0 && !bus.tx_valid) ok = 1'b1;
    end
    check({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_halt"},      32'(halt),          32'd1);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    check({tag, "_r_addr"},    32'(r_addr),        32'd0);
    check({tag, "_prog_done"}, 32'(prog_done),     32'd0);
    check({tag, "_state"},     32'(state),         32'(ST_IDLE));
  endtask

  // tx_ready source: steady 1 or a coin flip every cycle
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops expected bytes on each handshake, checks hold under backpressure, tracks halt
  initial begin
    bit         stall;
    bit         prev_halt;
    logic [7:0] held;
    stall = 1'b0; prev_halt = 1'b1; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0; prev_halt = 1'b1;
        continue;
      end
      if (stall) check("tx_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, held}));
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got %h required no byte", bus.tx_data);
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        byte_cnt++;
      end
      stall = bus.tx_valid && !bus.tx_ready;
      held  = bus.tx_data;
      if (!halt) begin
        low_cycles++;
        pc += 4;
        if (prev_halt) low_pulses++;
      end
      prev_halt = halt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc0, lp0, pc0, b0, w, dlen;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    prog_halt     = 1'b0;
    model_cycles  = '0;
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = 32'(k) * 32'h0101_0101;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 1'b0;

    // full dump, ready held high: latency, length, halt stays high
    lc0 = low_cycles;
    push_dump();
    send_cmd(CMD_DUMP);
    @(negedge clk);
    check("dump_load_state", 32'(state), 32'(ST_DUMP_LOAD));
    check("dump_lat_cycle1", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    check("dump_lat_cycle2", 32'(bus.tx_valid), 32'd1);
    dlen = 2;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (state == 3'(ST_IDLE)) break;
      dlen++;
    end
`ifdef DBG_CYCLE_COUNT_EN
    check("dump_length", 32'(dlen), 32'd164);
`else
    check("dump_length", 32'(dlen), 32'd160);
`endif
    wait_idle("dump1");
    check("dump1_halt_low", 32'(low_cycles - lc0), 32'd0);
    check("idle_r_addr", 32'(r_addr), 32'd0);

    // three single steps, then h and an unknown byte in IDLE
    pc0 = pc; lp0 = low_pulses; lc0 = low_cycles;
    repeat (3) send_cmd(CMD_STEP);
    model_cycles += 3;
    send_cmd(CMD_HALT);
    send_cmd(8'h41);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("step_low_cycles", 32'(low_cycles - lc0), 32'd3);
    check("step_pulses", 32'(low_pulses - lp0), 32'd3);
    check("step_pc", 32'(pc - pc0), 32'd12);
    check("idle_ignore_state", 32'(state), 32'(ST_IDLE));

    // fresh reset, run for 20 cycles with an ignored r in between
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_cycles = '0;
    lc0 = low_cycles;
    send_cmd(CMD_RUN);
    repeat (8) @(posedge clk);
    send_cmd(CMD_DUMP);
    repeat (8) @(posedge clk);
    send_cmd(CMD_HALT);
    model_cycles += 20;
    @(negedge clk);
    check("run_low_cycles", 32'(low_cycles - lc0), 32'd20);
    check("run_halt_state", 32'(state), 32'(ST_IDLE));

    // same register bank with random backpressure
    rand_ready = 1'b1;
    push_dump();
    send_cmd(CMD_DUMP);
    wait_idle("dump_backpressure");

    // random register contents
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = $urandom;
    push_dump();
    send_cmd(CMD_DUMP);
    wait_idle("dump_random");

    // program HALT while running, coinciding with an h command
    lc0 = low_cycles;
    send_cmd(CMD_RUN);
    w = int'($urandom_range(3, 15));
    repeat (w) @(posedge clk);
    #1;
    prog_halt     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = CMD_HALT;
    model_cycles += 32'(w + 1);
    push_dump();
    @(posedge clk); #1;
    prog_halt     = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("auto_dump_load", 32'(state), 32'(ST_DUMP_LOAD));
    check("prog_done_set", 32'(prog_done), 32'd1);
    @(negedge clk);
    check("auto_dump_valid", 32'(bus.tx_valid), 32'd1);
    wait_idle("auto_dump");
    check("auto_low_cycles", 32'(low_cycles - lc0), 32'(w + 1));

    // c and s are ignored once the program is done
    lc0 = low_cycles;
    send_cmd(CMD_RUN);
    send_cmd(CMD_STEP);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_ignore_state", 32'(state), 32'(ST_IDLE));
    check("done_ignore_halt", 32'(low_cycles - lc0), 32'd0);
    check("prog_done_sticky", 32'(prog_done), 32'd1);

    // reset at byte 50 of a dump, then a full dump restarts from reg 0
    rand_ready = 1'b0;
    push_dump();
    b0 = byte_cnt;
    send_cmd(CMD_DUMP);
    for (int i = 0; i < 2000 && (byte_cnt - b0) < 50; i++) @(negedge clk);
    check("abort_reached_50", 32'(byte_cnt - b0), 32'd50);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    reset_checks("abort");
    exp_q.delete();
    model_cycles = '0;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = $urandom;
    rand_ready = 1'b1;
    push_dump();
    send_cmd(CMD_DUMP);
    wait_idle("dump_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
